// File: rtl/posit_pd_encoder_if.sv
// Decoded-posit type helpers and the rts/rtr streaming interface carrying a decoded posit.
// SCALE_WIDTH / FRACTION_WIDTH are derived from the posit format and decoded-posit flavour.
package posit_defines;

    typedef enum logic [1:0] {
        NORMAL,
        PRODUCT,
        SUM
    } pd_type_t;

    // Signed scale width large enough for the full regime/exponent range plus one guard bit.
    function automatic int get_scale_width(input int n, input int es, input pd_type_t t);
        int w;
        w = $clog2(n) + es + 2;
        if (t != NORMAL) w = w + 1;
        return w;
    endfunction

    function automatic int get_fraction_width(input int n, input int es, input pd_type_t t);
        int w;
        w = n - es - 3;
        if (t == PRODUCT) w = 2 * w + 2;
        else if (t == SUM) w = w + 3;
        return w;
    endfunction

endpackage

interface pd_control_if
    import posit_defines::*;
#(
    parameter int       POSIT_WIDTH = 32,
    parameter int       POSIT_ES    = 2,
    parameter pd_type_t PD_TYPE     = NORMAL
);
    localparam int SCALE_WIDTH    = get_scale_width(POSIT_WIDTH, POSIT_ES, PD_TYPE);
    localparam int FRACTION_WIDTH = get_fraction_width(POSIT_WIDTH, POSIT_ES, PD_TYPE);

    logic                          rts;
    logic                          rtr;
    logic                          sow;
    logic                          eow;
    logic signed [SCALE_WIDTH-1:0] scale;
    logic [FRACTION_WIDTH-1:0]     fraction;
    logic                          NaR;
    logic                          sign;
    logic                          zero;
    logic                          guard;
    logic                          round;
    logic                          sticky;

    modport master (
        output rts, sow, eow, scale, fraction, NaR, sign, zero, guard, round, sticky,
        input  rtr
    );

    modport slave (
        input  rts, sow, eow, scale, fraction, NaR, sign, zero, guard, round, sticky,
        output rtr
    );

endinterface

// File: rtl/posit_pd_encoder.sv
// Two-stage posit encoder: decoded posit -> packed POSIT_WIDTH-bit word with regime saturation.
// Define POSIT_ENC_ROUND_EN for round-to-nearest-even; otherwise the encoding truncates.
module posit_pd_encoder
    import posit_defines::*;
#(
    parameter int       POSIT_WIDTH = 32,
    parameter int       POSIT_ES    = 2,
    parameter pd_type_t PD_TYPE     = NORMAL
) (
    input  logic                   clk,
    input  logic                   rst,
    pd_control_if.slave            pd,
    output logic [POSIT_WIDTH-1:0] posit_o,
    output logic                   rts_o,
    input  logic                   rtr_i,
    output logic                   sow_o,
    output logic                   eow_o
);

    localparam int SW  = get_scale_width(POSIT_WIDTH, POSIT_ES, PD_TYPE);
    localparam int FW  = get_fraction_width(POSIT_WIDTH, POSIT_ES, PD_TYPE);
    localparam int NM1 = POSIT_WIDTH - 1;
    localparam int TW  = POSIT_ES + FW + 3;
    localparam int XW  = NM1 + 1 + TW;
    localparam int SHW = $clog2(XW);

    localparam logic [NM1-1:0] MAXPOS = '1;
    localparam logic [NM1-1:0] MINPOS = NM1'(1);

    // ---------------- pipeline control ----------------
    logic s1_valid_q, s1_valid_d;
    logic s2_valid_q, s2_valid_d;
    logic s2_ready, s1_move, rtr, in_fire;

    assign s2_ready = !s2_valid_q || rtr_i;
    assign s1_move  = s1_valid_q && s2_ready;
    assign rtr      = !s1_valid_q || s2_ready;
    assign in_fire  = pd.rts && rtr;
    assign pd.rtr   = rtr;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s2_valid_d = s2_valid_q;
        if (in_fire) s1_valid_d = 1'b1;
        else if (s1_move) s1_valid_d = 1'b0;
        if (s1_move) s2_valid_d = 1'b1;
        else if (rtr_i) s2_valid_d = 1'b0;
    end

    // ---------------- stage 1: regime build ----------------
    logic signed [SW-1:0] k;
    logic                 rbit;
    logic [SW-1:0]        runlen;
    logic [SHW-1:0]       sh;
    logic [TW-1:0]        tail;
    logic [XW-1:0]        body;
    logic                 sat_hi, sat_lo;
    logic [NM1-1:0]       s1_trunc_d;
`ifdef POSIT_ENC_ROUND_EN
    logic [XW-1:0]        shifted;
    logic                 s1_g_d, s1_s_d;
`endif

    if (POSIT_ES > 0) begin : g_exp
        assign tail = {pd.scale[POSIT_ES-1:0], pd.fraction, pd.guard, pd.round, pd.sticky};
    end else begin : g_noexp
        assign tail = {pd.fraction, pd.guard, pd.round, pd.sticky};
    end

    // body = run of NM1 regime bits, terminator, tail; shifting left by NM1-runlen leaves
    // exactly runlen regime bits at the top, so the kept N-1 bits start at the MSB.
    always_comb begin
        k      = pd.scale >>> POSIT_ES;
        rbit   = !k[SW-1];
        runlen = rbit ? k + SW'(1) : -k;
        sh     = SHW'(NM1) - SHW'(runlen);
        sat_hi = k >= $signed(SW'(POSIT_WIDTH - 2));
        sat_lo = k <= $signed(SW'(-NM1));
        body   = {{NM1{rbit}}, !rbit, tail};
`ifdef POSIT_ENC_ROUND_EN
        shifted    = body << sh;
        s1_trunc_d = shifted[XW-1 -: NM1];
        s1_g_d     = shifted[TW];
        s1_s_d     = |shifted[TW-1:0];
        if (sat_hi || sat_lo) begin
            s1_trunc_d = sat_hi ? MAXPOS : MINPOS;
            s1_g_d     = 1'b0;
            s1_s_d     = 1'b0;
        end
`else
        s1_trunc_d = NM1'(body >> (SHW'(TW + 1) - sh));
        if (sat_hi || sat_lo) s1_trunc_d = sat_hi ? MAXPOS : MINPOS;
`endif
    end

    logic [NM1-1:0] s1_trunc_q;
    logic           s1_sign_q, s1_nar_q, s1_zero_q, s1_sow_q, s1_eow_q;
`ifdef POSIT_ENC_ROUND_EN
    logic           s1_g_q, s1_s_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_trunc_q <= '0;
            s1_sign_q  <= 1'b0;
            s1_nar_q   <= 1'b0;
            s1_zero_q  <= 1'b0;
            s1_sow_q   <= 1'b0;
            s1_eow_q   <= 1'b0;
`ifdef POSIT_ENC_ROUND_EN
            s1_g_q     <= 1'b0;
            s1_s_q     <= 1'b0;
`endif
        end else begin
            s1_valid_q <= s1_valid_d;
            if (in_fire) begin
                s1_trunc_q <= s1_trunc_d;
                s1_sign_q  <= pd.sign;
                s1_nar_q   <= pd.NaR;
                s1_zero_q  <= pd.zero;
                s1_sow_q   <= pd.sow;
                s1_eow_q   <= pd.eow;
`ifdef POSIT_ENC_ROUND_EN
                s1_g_q     <= s1_g_d;
                s1_s_q     <= s1_s_d;
`endif
            end
        end
    end

    // ---------------- stage 2: round and sign ----------------
    logic [NM1-1:0]         mag;
    logic [POSIT_WIDTH-1:0] posit_d;
`ifdef POSIT_ENC_ROUND_EN
    logic                   inc;
    logic [NM1:0]           sum;
`endif

    always_comb begin
`ifdef POSIT_ENC_ROUND_EN
        inc = s1_g_q & (s1_s_q | s1_trunc_q[0]);
        sum = {1'b0, s1_trunc_q} + {{NM1{1'b0}}, inc};
        mag = sum[NM1] ? MAXPOS : sum[NM1-1:0];
        if (mag == '0) mag = MINPOS;
`else
        mag = s1_trunc_q;
`endif
        if (s1_nar_q) posit_d = {1'b1, {NM1{1'b0}}};
        else if (s1_zero_q) posit_d = '0;
        else if (s1_sign_q) posit_d = -{1'b0, mag};
        else posit_d = {1'b0, mag};
    end

    logic [POSIT_WIDTH-1:0] posit_q;
    logic                   sow_q, eow_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid_q <= 1'b0;
            posit_q    <= '0;
            sow_q      <= 1'b0;
            eow_q      <= 1'b0;
        end else begin
            s2_valid_q <= s2_valid_d;
            if (s1_move) begin
                posit_q <= posit_d;
                sow_q   <= s1_sow_q;
                eow_q   <= s1_eow_q;
            end
        end
    end

    assign posit_o = posit_q;
    assign rts_o   = s2_valid_q;
    assign sow_o   = sow_q;
    assign eow_o   = eow_q;

endmodule

// File: tb/tb_posit_pd_encoder.sv
// Self-checking bench for posit_pd_encoder (N=8, ES=0): directed vectors, backpressure,
// framing, mid-stream reset and randomized streams against a bit-queue reference model.
module tb_posit_pd_encoder;
    import posit_defines::*;

    localparam int N  = 8;
    localparam int ES = 0;
    localparam int SW = get_scale_width(N, ES, NORMAL);
    localparam int FW = get_fraction_width(N, ES, NORMAL);

    typedef struct {
        int            scale;
        logic [FW-1:0] frac;
        bit            sign, zero, nar, g, r, st, sow, eow;
    } word_t;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] posit_o;
    logic         rts_o, rtr_i, sow_o, eow_o;

    int           n_checks = 0;
    int           n_errors = 0;
    logic [N+1:0] exp_q[$];

    always #5 clk = ~clk;

    pd_control_if #(.POSIT_WIDTH(N), .POSIT_ES(ES), .PD_TYPE(NORMAL)) pd_if ();

    posit_pd_encoder #(.POSIT_WIDTH(N), .POSIT_ES(ES), .PD_TYPE(NORMAL)) dut (
        .clk     (clk),
        .rst     (rst),
        .pd      (pd_if),
        .posit_o (posit_o),
        .rts_o   (rts_o),
        .rtr_i   (rtr_i),
        .sow_o   (sow_o),
        .eow_o   (eow_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: value -> regime/exponent/fraction bit list, keep N-1 bits, round on the rest.
    function automatic logic [N-1:0] ref_enc(input word_t w);
        bit q[$];
        int k, e, mag, maxpos;
`ifdef POSIT_ENC_ROUND_EN
        int gb, sb;
`endif
        maxpos = (1 << (N - 1)) - 1;
        if (w.nar) return {1'b1, {(N-1){1'b0}}};
        if (w.zero) return '0;
        k = (w.scale < 0) ? -((-w.scale + (1 << ES) - 1) / (1 << ES)) : w.scale / (1 << ES);
        e = w.scale - k * (1 << ES);
        if (k >= N - 2) mag = maxpos;
        else if (k <= -(N - 1)) mag = 1;
        else begin
            if (k >= 0) begin
                repeat (k + 1) q.push_back(1'b1);
                q.push_back(1'b0);
            end else begin
                repeat (-k) q.push_back(1'b0);
                q.push_back(1'b1);
            end
            for (int unsigned i = 0; i < ES; i++) q.push_back(e[ES-1-i]);
            for (int unsigned i = 0; i < FW; i++) q.push_back(w.frac[FW-1-i]);
            q.push_back(w.g);
            q.push_back(w.r);
            q.push_back(w.st);
            mag = 0;
            for (int unsigned i = 0; i < N - 1; i++) mag = mag * 2 + int'(q[i]);
`ifdef POSIT_ENC_ROUND_EN
            gb = int'(q[N-1]);
            sb = 0;
            for (int unsigned i = N; i < q.size(); i++) sb = sb | int'(q[i]);
            if (gb != 0 && (sb != 0 || (mag % 2) == 1)) mag++;
            if (mag > maxpos) mag = maxpos;
`endif
            if (mag == 0) mag = 1;
        end
        if (w.sign) mag = (1 << N) - mag;
        return N'(mag);
    endfunction

    function automatic word_t mk(input int sc, input int fr, input bit sn, input bit z,
                                 input bit nr, input bit g, input bit r, input bit st);
        word_t w;
        w.scale = sc; w.frac = FW'(fr); w.sign = sn; w.zero = z; w.nar = nr;
        w.g = g; w.r = r; w.st = st; w.sow = 1'b0; w.eow = 1'b0;
        return w;
    endfunction

    function automatic word_t rand_word();
        word_t w;
        w.scale = int'($urandom_range(24)) - 12;
        w.frac  = FW'($urandom);
        w.sign  = 1'($urandom);
        w.zero  = ($urandom_range(9) == 0);
        w.nar   = ($urandom_range(15) == 0);
        w.g     = 1'($urandom);
        w.r     = 1'($urandom);
        w.st    = 1'($urandom);
        w.sow   = 1'b0;
        w.eow   = 1'b0;
        return w;
    endfunction

    task automatic drive_word(input word_t w);
        pd_if.scale    = SW'(w.scale);
        pd_if.fraction = w.frac;
        pd_if.sign     = w.sign;
        pd_if.zero     = w.zero;
        pd_if.NaR      = w.nar;
        pd_if.guard    = w.g;
        pd_if.round    = w.r;
        pd_if.sticky   = w.st;
        pd_if.sow      = w.sow;
        pd_if.eow      = w.eow;
    endtask

    // One word through an idle pipeline; checks value and 2-cycle latency.
    task automatic single(input string tag, input word_t w, input logic [N-1:0] expv);
        int lat;
        int c;
        rtr_i = 1'b1;
        drive_word(w);
        pd_if.rts = 1'b1;
        @(negedge clk);
        c = 0;
        while (!pd_if.rtr && c < 20) begin
            @(negedge clk);
            c++;
        end
        @(posedge clk);
        #1 pd_if.rts = 1'b0;
        lat = 0;
        for (int unsigned n = 1; n <= 6 && lat == 0; n++) begin
            @(negedge clk);
            if (rts_o) lat = int'(n);
        end
        check({tag, "_latency"}, lat, 2);
        check(tag, posit_o, expv);
        @(posedge clk);
        #1;
    endtask

    // mode 0: rtr_i held low for 8 cycles then high; mode 1: random stalls/gaps, sow word 1, eow word 4.
    task automatic stream(input string tag, input int nw, input int mode);
        word_t        w[$];
        int           idx, acc, outs, cyc, first_out, last_out;
        bit           prev_stall;
        logic [N+1:0] prev_v, e;
        idx = 0; acc = 0; outs = 0; cyc = 0; first_out = -1; last_out = -1;
        prev_stall = 1'b0; prev_v = '0;
        exp_q.delete();
        for (int i = 0; i < nw; i++) begin
            w.push_back(rand_word());
            w[i].sow = (mode == 1 && i == 0);
            w[i].eow = (mode == 1 && i == 3);
        end
        rtr_i = (mode == 1) ? ($urandom_range(3) != 0) : 1'b0;
        drive_word(w[0]);
        pd_if.rts = 1'b1;
        while (outs < nw && cyc < nw * 10 + 50) begin
            @(negedge clk);
            if (prev_stall) begin
                check({tag, "_hold_valid"}, rts_o, 1);
                check({tag, "_hold_data"}, {sow_o, eow_o, posit_o}, prev_v);
            end
            if (pd_if.rts && pd_if.rtr) begin
                exp_q.push_back({w[idx].sow, w[idx].eow, ref_enc(w[idx])});
                idx++;
                acc++;
            end
            if (rts_o && rtr_i) begin
                check({tag, "_expected_word"}, exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check({tag, "_word"}, {sow_o, eow_o, posit_o}, e);
                end
                outs++;
                if (first_out < 0) first_out = cyc;
                last_out = cyc;
            end
            prev_stall = rts_o && !rtr_i;
            prev_v     = {sow_o, eow_o, posit_o};
            if (mode == 0 && cyc == 7) begin
                check({tag, "_accepts_while_full"}, acc, 2);
                check({tag, "_rtr_full"}, pd_if.rtr, 0);
            end
            @(posedge clk);
            #1;
            cyc++;
            rtr_i = (mode == 0) ? (cyc >= 8) : ($urandom_range(3) != 0);
            if (idx < nw) begin
                drive_word(w[idx]);
                pd_if.rts = (mode == 0) ? 1'b1 : ($urandom_range(3) != 0);
            end else begin
                pd_if.rts = 1'b0;
            end
        end
        check({tag, "_outputs"}, outs, nw);
        check({tag, "_leftover"}, exp_q.size(), 0);
        if (mode == 0) check({tag, "_contiguous"}, last_out - first_out, nw - 1);
        rtr_i = 1'b1;
    endtask

    task automatic reset_mid();
        int acc;
        int outs;
        rtr_i = 1'b0;
        acc = 0;
        drive_word(rand_word());
        pd_if.rts = 1'b1;
        for (int c = 0; c < 10 && acc < 2; c++) begin
            @(negedge clk);
            if (pd_if.rtr) acc++;
            @(posedge clk);
            #1 drive_word(rand_word());
        end
        pd_if.rts = 1'b0;
        @(negedge clk);
        check("rstmid_full_rtr", pd_if.rtr, 0);
        check("rstmid_full_rts_o", rts_o, 1);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rstmid_rts_o", rts_o, 0);
        check("rstmid_rtr", pd_if.rtr, 1);
        rtr_i = 1'b1;
        outs = 0;
        repeat (6) begin
            @(negedge clk);
            if (rts_o) outs++;
        end
        check("rstmid_no_stale", outs, 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst   = 1'b1;
        rtr_i = 1'b0;
        pd_if.rts = 1'b0;
        drive_word(mk(0, 0, 0, 0, 0, 0, 0, 0));
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_rts_o", rts_o, 0);
        check("reset_posit_o", posit_o, 0);
        check("reset_sow_o", sow_o, 0);
        check("reset_eow_o", eow_o, 0);
        check("reset_rtr", pd_if.rtr, 1);
        @(posedge clk);
        #1;

        single("basic_one",    mk(0, 0, 0, 0, 0, 0, 0, 0), 8'h40);
        single("basic_two",    mk(1, 0, 0, 0, 0, 0, 0, 0), 8'h60);
        single("basic_neg",    mk(0, 0, 1, 0, 0, 0, 0, 0), 8'hC0);
        single("nar_over_zero", mk(0, 0, 0, 1, 1, 0, 0, 0), 8'h80);
        single("zero_signed",  mk(3, 7, 1, 1, 0, 0, 0, 0), 8'h00);
        single("sat_max_6",    mk(6, 0, 0, 0, 0, 1, 1, 1), 8'h7F);
        single("sat_max_10",   mk(10, 0, 0, 0, 0, 0, 0, 0), 8'h7F);
        single("edge_k5",      mk(5, 0, 0, 0, 0, 0, 0, 0), 8'h7E);
        single("edge_km5",     mk(-5, 0, 0, 0, 0, 0, 0, 0), 8'h02);
        single("edge_km6",     mk(-6, 0, 0, 0, 0, 0, 0, 0), 8'h01);
        single("sat_min",      mk(-10, 0, 0, 0, 0, 0, 0, 0), 8'h01);
        single("sat_min_neg",  mk(-10, 0, 1, 0, 0, 0, 0, 0), 8'hFF);
        single("rnd_tie_even", mk(0, 0, 0, 0, 0, 1, 0, 0), 8'h40);
`ifdef POSIT_ENC_ROUND_EN
        single("rnd_sticky",   mk(0, 0, 0, 0, 0, 1, 0, 1), 8'h41);
        single("rnd_odd",      mk(0, 1, 0, 0, 0, 1, 0, 0), 8'h42);
`else
        single("rnd_sticky",   mk(0, 0, 0, 0, 0, 1, 0, 1), 8'h40);
        single("rnd_odd",      mk(0, 1, 0, 0, 0, 1, 0, 0), 8'h41);
`endif

        stream("bp", 5, 0);
        for (int unsigned r = 0; r < 4; r++) stream("frame", 12, 1);
        reset_mid();
        stream("rand", 60, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not reach the end, observed timeout");
        $fatal(1, "watchdog timeout");
    end

endmodule
